coeff_bank_server: RTL and testbench



---
 rtl/coeff_bank_server_if.sv | 41 ++++
 rtl/coeff_bank_server.sv | 129 ++++++++++++
 tb/tb_coeff_bank_server.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_bank_server_if.sv
// Filter/host-facing bundle of coeff_bank_server; ld_checksum exists only with COEFF_CHECKSUM_EN.
interface coeff_bank_server_if #(
  parameter int AW = 6,
  parameter int CW = 36
);
  logic [AW-1:0] coeffaddress;
  logic [CW-1:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
  logic          active_valid;
  logic          ld_start;
  logic          ld_valid;
  logic [CW-1:0] ld_data;
  logic          ld_ready;
  logic          shadow_full;
  logic          swap_req;
  logic          swap_ack;
`ifdef COEFF_CHECKSUM_EN
  logic [CW-1:0] ld_checksum;

  modport slave (
    input  coeffaddress, ld_start, ld_valid, ld_data, swap_req,
    output coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7,
    output active_valid, ld_ready, shadow_full, swap_ack, ld_checksum
  );
  modport master (
    output coeffaddress, ld_start, ld_valid, ld_data, swap_req,
    input  coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7,
    input  active_valid, ld_ready, shadow_full, swap_ack, ld_checksum
  );
`else
  modport slave (
    input  coeffaddress, ld_start, ld_valid, ld_data, swap_req,
    output coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7,
    output active_valid, ld_ready, shadow_full, swap_ack
  );
  modport master (
    output coeffaddress, ld_start, ld_valid, ld_data, swap_req,
    input  coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7,
    input  active_valid, ld_ready, shadow_full, swap_ack
  );
`endif
endinterface

// File: rtl/coeff_bank_server.sv
// Double-buffered coefficient store for the 8-channel FIR: 1-cycle free-running read of the active set,
// host streams the shadow set then swaps atomically. COEFF_CHECKSUM_EN adds a running ld_checksum.
module coeff_bank_server #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CW    = 36
) (
  input logic                clock,
  input logic                reset,
  coeff_bank_server_if.slave io_bus
);
  localparam int NCH = 8;
  localparam int KW  = $clog2(NCH * DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic          r_active_sel;
  logic          r_active_valid;
  logic          r_ld_ready;
  logic          r_shadow_full;
  logic          r_swap_ack;
  logic [CW-1:0] r_mem [2][NCH][DEPTH];
  logic [CW-1:0] r_coeff [NCH];

  logic          w_accept;
  logic [2:0]    w_ch;
  logic [AW-1:0] w_wr_addr;

  // A same-cycle ld_start discards the word presented with it.
  assign w_accept  = (r_state == LOAD) && io_bus.ld_valid && !io_bus.ld_start;
  assign w_ch      = r_k[2:0];
  assign w_wr_addr = r_k[KW-1:3];

  always_ff @(posedge clock) begin
    if (w_accept)
      r_mem[~r_active_sel][w_ch][w_wr_addr] <= io_bus.ld_data;
  end

  always_ff @(posedge clock) begin
    for (int n = 0; n < NCH; n++) begin
      if (reset || !r_active_valid)
        r_coeff[n] <= '0;
      else
        r_coeff[n] <= r_mem[r_active_sel][n][io_bus.coeffaddress];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_k            <= '0;
      r_active_sel   <= 1'b0;
      r_active_valid <= 1'b0;
      r_ld_ready     <= 1'b0;
      r_shadow_full  <= 1'b0;
      r_swap_ack     <= 1'b0;
    end else begin
      r_swap_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.ld_start) begin
            r_state    <= LOAD;
            r_k        <= '0;
            r_ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (io_bus.ld_start) begin
            r_k <= '0;
          end else if (io_bus.ld_valid) begin
            r_k <= r_k + KW'(1);
            if (r_k == KW'(NCH * DEPTH - 1)) begin
              r_state       <= FULL;
              r_ld_ready    <= 1'b0;
              r_shadow_full <= 1'b1;
            end
          end
        end
        FULL: begin
          // Swap wins over a coincident restart.
          if (io_bus.swap_req) begin
            r_state        <= IDLE;
            r_active_sel   <= ~r_active_sel;
            r_active_valid <= 1'b1;
            r_swap_ack     <= 1'b1;
            r_shadow_full  <= 1'b0;
          end else if (io_bus.ld_start) begin
            r_state       <= LOAD;
            r_k           <= '0;
            r_ld_ready    <= 1'b1;
            r_shadow_full <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef COEFF_CHECKSUM_EN
  logic [CW-1:0] r_checksum;
  logic          w_restart;

  assign w_restart = io_bus.ld_start && !(r_state == FULL && io_bus.swap_req);

  always_ff @(posedge clock) begin
    if (reset || w_restart)
      r_checksum <= '0;
    else if (w_accept)
      r_checksum <= r_checksum + io_bus.ld_data;
  end

  assign io_bus.ld_checksum = r_checksum;
`endif

  assign io_bus.coeff0       = r_coeff[0];
  assign io_bus.coeff1       = r_coeff[1];
  assign io_bus.coeff2       = r_coeff[2];
  assign io_bus.coeff3       = r_coeff[3];
  assign io_bus.coeff4       = r_coeff[4];
  assign io_bus.coeff5       = r_coeff[5];
  assign io_bus.coeff6       = r_coeff[6];
  assign io_bus.coeff7       = r_coeff[7];
  assign io_bus.active_valid = r_active_valid;
  assign io_bus.ld_ready     = r_ld_ready;
  assign io_bus.shadow_full  = r_shadow_full;
  assign io_bus.swap_ack     = r_swap_ack;
endmodule

// File: tb/tb_coeff_bank_server.sv
// Scoreboard bench for coeff_bank_server: a set-level model predicts every registered output cycle by cycle.
module tb_coeff_bank_server;
  localparam int AW = 6;
  localparam int CW = 36;
  localparam int NW = 512;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  coeff_bank_server_if #(.AW(AW), .CW(CW)) bus ();

  coeff_bank_server #(.DEPTH(64), .AW(AW), .CW(CW)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0][CW-1:0] coeff;
    logic               av;
    logic               rdy;
    logic               full;
    logic               ack;
    logic [CW-1:0]      cks;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: contents of the active and shadow sets as flat word lists (index k = addr*8 + channel).
  logic [CW-1:0] m_act [NW];
  logic [CW-1:0] m_shd [NW];
  logic [CW-1:0] m_tmp [NW];
  int            m_mode = 0;  // 0 idle, 1 loading, 2 shadow complete
  int            m_k = 0;
  bit            m_valid = 1'b0;
  logic [CW-1:0] m_cks = '0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int addr, input bit start, input bit vld,
                       input logic [CW-1:0] data, input bit swap, input bit rst);
    exp_t e;
    @(negedge clock);
    reset             = rst;
    bus.coeffaddress  = AW'(addr);
    bus.ld_start      = start;
    bus.ld_valid      = vld;
    bus.ld_data       = data;
    bus.swap_req      = swap;
    e = '0;
    for (int n = 0; n < 8; n++)
      e.coeff[n] = (!rst && m_valid) ? m_act[addr * 8 + n] : '0;
    if (rst) begin
      m_mode = 0; m_k = 0; m_valid = 1'b0; m_cks = '0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_k = 0; m_cks = '0; end
        1: begin
          if (start) begin
            m_k = 0; m_cks = '0;
          end else if (vld) begin
            m_shd[m_k] = data;
            m_cks = m_cks + data;
            m_k++;
            if (m_k == NW) m_mode = 2;
          end
        end
        default: begin
          if (swap) begin
            m_tmp = m_act; m_act = m_shd; m_shd = m_tmp;
            m_valid = 1'b1; e.ack = 1'b1; m_mode = 0;
          end else if (start) begin
            m_mode = 1; m_k = 0; m_cks = '0;
          end
        end
      endcase
    end
    e.av   = m_valid;
    e.rdy  = (m_mode == 1);
    e.full = (m_mode == 2);
    e.cks  = m_cks;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input int addr);
    repeat (n) drive(addr, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic stream(input int n, input logic [CW-1:0] base, input int pct, input int addr);
    int cnt;
    bit v;
    cnt = 0;
    while (cnt < n) begin
      v = ($urandom_range(99) < pct);
      drive((addr < 0) ? int'($urandom_range(63)) : addr, 1'b0, v, base + CW'(cnt), 1'b0, 1'b0);
      if (v) cnt++;
    end
  endtask

  task automatic direct(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vectors++;
    chk(name, act, exp);
  endtask

  // Monitor: every cycle presents a registered read, so pop one prediction per edge.
  initial begin
    exp_t e;
    logic [7:0][CW-1:0] act;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        act = {bus.coeff7, bus.coeff6, bus.coeff5, bus.coeff4,
               bus.coeff3, bus.coeff2, bus.coeff1, bus.coeff0};
        for (int n = 0; n < 8; n++)
          chk($sformatf("coeff%0d", n), act[n], e.coeff[n]);
        chk("active_valid", CW'(bus.active_valid), CW'(e.av));
        chk("ld_ready", CW'(bus.ld_ready), CW'(e.rdy));
        chk("shadow_full", CW'(bus.shadow_full), CW'(e.full));
        chk("swap_ack", CW'(bus.swap_ack), CW'(e.ack));
`ifdef COEFF_CHECKSUM_EN
        chk("ld_checksum", bus.ld_checksum, e.cks);
`endif
      end
    end
  end

  initial begin
    int wait_cycles;
    logic [CW-1:0] d;
    bus.coeffaddress = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.swap_req = 1'b0;

    // Reset and idle reads.
    drive(5, 0, 0, '0, 0, 1);
    drive(5, 0, 0, '0, 0, 1);
    drive(5, 0, 1, 36'd77, 0, 0);
    idle(3, 5);

    // First set: word k = k, back-to-back.
    drive(5, 1, 0, '0, 0, 0);
    stream(NW, '0, 100, -1);
    idle(2, 3);
    drive(3, 0, 0, '0, 1, 0);
    drive(3, 0, 0, '0, 0, 0);
    @(posedge clock); #1;
    direct("t2_coeff7", bus.coeff7, 36'd31);
    idle(2, 3);

    // Second set 1000+k with gaps while reading address 63.
    drive(63, 1, 0, '0, 0, 0);
    stream(NW, 36'd1000, 70, 63);
    @(posedge clock); #1;
    direct("t3_coeff0_old", bus.coeff0, 36'd504);
    drive(63, 0, 0, '0, 1, 0);
    drive(63, 0, 0, '0, 0, 0);
    @(posedge clock); #1;
    direct("t3_coeff0_new", bus.coeff0, 36'd1504);

    // Restart after a partial load.
    drive(0, 1, 0, '0, 0, 0);
    stream(100, 36'd5000, 90, -1);
    drive(0, 1, 1, 36'd4242, 0, 0);
    stream(NW, 36'd7000, 90, -1);
    drive(0, 0, 0, '0, 1, 0);
    drive(0, 0, 0, '0, 0, 0);
    @(posedge clock); #1;
    direct("t4_coeff0", bus.coeff0, 36'd7000);

    // Swap requests in IDLE and LOAD are ignored; swap beats ld_start in FULL.
    drive(9, 0, 0, '0, 1, 0);
    drive(9, 1, 0, '0, 0, 0);
    stream(40, 36'd300, 100, -1);
    drive(9, 0, 1, 36'd99, 1, 0);
    stream(NW - 41, 36'd341, 100, -1);
    idle(1, 9);
    drive(9, 1, 0, '0, 1, 0);
    idle(3, 9);

    // Reset mid-load, then a checksum-sized stream of k.
    drive(1, 1, 0, '0, 0, 0);
    stream(300, 36'd20000, 100, -1);
    drive(1, 0, 1, 36'd5, 0, 1);
    idle(3, 1);
    drive(1, 1, 0, '0, 0, 0);
    stream(NW, '0, 85, -1);
    @(posedge clock); #1;
`ifdef COEFF_CHECKSUM_EN
    direct("t6_checksum", bus.ld_checksum, 36'd130816);
`endif
    drive(2, 0, 0, '0, 1, 0);
    idle(3, 2);

    // Random traffic shaped by the model's phase so loads complete now and then.
    for (int i = 0; i < 3000; i++) begin
      bit s, w, v, r;
      d = CW'({32'($urandom), 32'($urandom)});
      r = ($urandom_range(1499) == 0);
      v = ($urandom_range(9) < 8);
      case (m_mode)
        0:       begin s = ($urandom_range(19) == 0);   w = ($urandom_range(9) == 0); end
        1:       begin s = ($urandom_range(1999) == 0); w = ($urandom_range(49) == 0); end
        default: begin s = ($urandom_range(9) == 0);    w = ($urandom_range(4) == 0); end
      endcase
      drive(int'($urandom_range(63)), s, v, d, w, r);
    end
    idle(2, 0);

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
